button_press_emulator: RTL and testbench

- Synthesizable generator of active-low, bouncy push-button waveforms: the driving end of the button-input path.
- Emits a programmed number of press/release cycles on btn_n. Each press has mechanical-style bounce at both edges, a hold time, and an inter-press gap.
- Used for on-board closed-loop checks (btn_n looped back to the debounced counter's button pin) and as a reusable simulation stimulus source.

---
 rtl/button_pkg.sv | 21 ++
 rtl/button_press_emulator_ms_tick_prescaler.sv | 35 +++
 rtl/button_press_emulator.sv | 167 ++++++++++++++++
 tb/tb_button_press_emulator.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/button_pkg.sv
// Shared constants for both ends of the push-button path.
// States, default ms timings, LFSR seed and feedback taps.
package button_pkg;

  localparam logic [2:0] ST_IDLE         = 3'd0;
  localparam logic [2:0] ST_PRESS_BOUNCE = 3'd1;
  localparam logic [2:0] ST_HOLD         = 3'd2;
  localparam logic [2:0] ST_REL_BOUNCE   = 3'd3;
  localparam logic [2:0] ST_GAP          = 3'd4;

  localparam int DEF_CLK_TICKS_PER_MS  = 12000;
  localparam int DEF_BOUNCE_MS         = 2;
  localparam int DEF_HOLD_MS           = 20;
  localparam int DEF_GAP_MS            = 20;
  localparam int DEF_BOUNCE_STEP_TICKS = 600;

  localparam logic [7:0] DEF_LFSR_SEED = 8'hA5;
  // Right-shift Galois form of x^8+x^6+x^5+x^4+1
  localparam logic [7:0] LFSR_TAPS     = 8'hB8;

endpackage

// File: rtl/button_press_emulator_ms_tick_prescaler.sv
// Millisecond prescaler: counts 0..TICKS-1 while en is high.
// Ports: clk, rst, en, clr (restart at 0), tick (last count of a ms).
module ms_tick_prescaler
  import button_pkg::*;
#(
  parameter int TICKS = DEF_CLK_TICKS_PER_MS
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int W = (TICKS > 1) ? $clog2(TICKS) : 1;
  localparam logic [W-1:0] LAST = W'(TICKS - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr || !en) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + W'(1);
    end
  end

  // Independent of clr: clr is itself derived from tick
  assign tick = en && (cnt == LAST);

endmodule

// File: rtl/button_press_emulator.sv
// Bouncy active-low push-button waveform generator.
// Ports: clk, rst, start, abort, press_count -> btn_n, busy, done, presses_sent.
module button_press_emulator
  import button_pkg::*;
#(
  parameter int         CLK_TICKS_PER_MS  = DEF_CLK_TICKS_PER_MS,
  parameter int         BOUNCE_MS         = DEF_BOUNCE_MS,
  parameter int         HOLD_MS           = DEF_HOLD_MS,
  parameter int         GAP_MS            = DEF_GAP_MS,
  parameter int         BOUNCE_STEP_TICKS = DEF_BOUNCE_STEP_TICKS,
  parameter logic [7:0] LFSR_SEED         = DEF_LFSR_SEED
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic [3:0] press_count,
  output logic       btn_n,
  output logic       busy,
  output logic       done,
  output logic [3:0] presses_sent
);

  localparam logic [15:0] D_BOUNCE = 16'(BOUNCE_MS);
  localparam logic [15:0] D_HOLD   = 16'(HOLD_MS);
  localparam logic [15:0] D_GAP    = 16'(GAP_MS);
  localparam bit          NO_BNC   = (BOUNCE_MS == 0);
  localparam logic [2:0]  FIRST    =
    NO_BNC ? ST_HOLD : ST_PRESS_BOUNCE;

  localparam int SW =
    (BOUNCE_STEP_TICKS > 1) ? $clog2(BOUNCE_STEP_TICKS) : 1;
  localparam logic [SW-1:0] STEP_LAST =
    SW'(BOUNCE_STEP_TICKS - 1);

  logic [2:0]    state;
  logic [2:0]    state_d;
  logic [3:0]    target;
  logic [15:0]   ms_cnt;
  logic [15:0]   cur_dur;
  logic [SW-1:0] step_cnt;
  logic [7:0]    lfsr;
  logic [7:0]    lfsr_nx;
  logic [3:0]    sent_inc;
  logic          last;
  logic          tick;
  logic          state_end;
  logic          start_go;
  logic          complete;
  logic          clr;
  logic          in_bounce;

  assign lfsr_nx =
    {1'b0, lfsr[7:1]} ^ (lfsr[0] ? LFSR_TAPS : 8'h00);

  assign sent_inc  = presses_sent + 4'd1;
  assign last      = (sent_inc == target);
  assign start_go  = (state == ST_IDLE) && start &&
                     (press_count != 4'd0);
  assign in_bounce = (state == ST_PRESS_BOUNCE) ||
                     (state == ST_REL_BOUNCE);

  always_comb begin
    cur_dur = 16'd1;
    unique case (1'b1)
      (state == ST_PRESS_BOUNCE),
      (state == ST_REL_BOUNCE): cur_dur = D_BOUNCE;
      (state == ST_HOLD):       cur_dur = D_HOLD;
      (state == ST_GAP):        cur_dur = D_GAP;
      default:                  cur_dur = 16'd1;
    endcase
  end

  assign state_end = tick && (ms_cnt == cur_dur - 16'd1);

  always_comb begin
    state_d  = state;
    complete = 1'b0;
    if (state == ST_IDLE) begin
      if (start_go) state_d = FIRST;
    end else if (abort) begin
      state_d = ST_IDLE;
    end else if (state_end) begin
      unique case (1'b1)
        (state == ST_PRESS_BOUNCE): state_d = ST_HOLD;
        (state == ST_HOLD): begin
          if (NO_BNC) complete = 1'b1;
          else        state_d  = ST_REL_BOUNCE;
        end
        (state == ST_REL_BOUNCE):   complete = 1'b1;
        (state == ST_GAP):          state_d  = FIRST;
        default:                    state_d  = ST_IDLE;
      endcase
      if (complete) state_d = last ? ST_IDLE : ST_GAP;
    end
  end

  // Every state change restarts the ms timing base
  assign clr = (state_d != state);

  ms_tick_prescaler #(
    .TICKS(CLK_TICKS_PER_MS)
  ) u_presc (
    .clk (clk),
    .rst (rst),
    .en  (busy),
    .clr (clr),
    .tick(tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      target       <= 4'd0;
      ms_cnt       <= 16'd0;
      step_cnt     <= '0;
      lfsr         <= LFSR_SEED;
      btn_n        <= 1'b1;
      busy         <= 1'b0;
      done         <= 1'b0;
      presses_sent <= 4'd0;
    end else begin
      state <= state_d;
      busy  <= (state_d != ST_IDLE);
      done  <= 1'b0;

      if ((state == ST_IDLE) && start &&
          (press_count == 4'd0)) begin
        done <= 1'b1;
      end

      if (start_go) begin
        target       <= press_count;
        presses_sent <= 4'd0;
      end

      if (complete) begin
        presses_sent <= sent_inc;
        if (last) done <= 1'b1;
      end

      if (clr) begin
        ms_cnt   <= 16'd0;
        step_cnt <= '0;
        // Bounce windows open with a press (btn_n=0)
        unique case (1'b1)
          (state_d == ST_PRESS_BOUNCE),
          (state_d == ST_REL_BOUNCE),
          (state_d == ST_HOLD): btn_n <= 1'b0;
          default:              btn_n <= 1'b1;
        endcase
      end else begin
        if (tick) ms_cnt <= ms_cnt + 16'd1;
        if (in_bounce) begin
          if (step_cnt == STEP_LAST) begin
            step_cnt <= '0;
            lfsr     <= lfsr_nx;
            btn_n    <= lfsr_nx[0];
          end else begin
            step_cnt <= step_cnt + SW'(1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_button_press_emulator.sv
// Directed self-checking bench for button_press_emulator.
// Expected waveforms come from an independent LFSR/timing model.
module tb_button_press_emulator;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       abort;
  logic [3:0] press_count;
  logic       btn_n;
  logic       busy;
  logic       done;
  logic [3:0] presses_sent;

  int n_run = 0;
  int n_fail = 0;

  logic [7:0] mdl_lfsr;
  int exp_b[$];
  int exp_p[$];

  always #5 clk = ~clk;

  button_press_emulator #(
    .CLK_TICKS_PER_MS (4),
    .BOUNCE_MS        (2),
    .HOLD_MS          (3),
    .GAP_MS           (2),
    .BOUNCE_STEP_TICKS(1),
    .LFSR_SEED        (8'hA5)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .abort       (abort),
    .press_count (press_count),
    .btn_n       (btn_n),
    .busy        (busy),
    .done        (done),
    .presses_sent(presses_sent)
  );

  task automatic chk(input string tag, input int got,
                     input int exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] lfsr_step(input logic [7:0] s);
    logic [7:0] r;
    r = s >> 1;
    if (s[0]) r = r ^ 8'b1011_1000;
    return r;
  endfunction

  task automatic tick1();
    @(posedge clk);
    #1;
  endtask

  // Bounce window: one forced low, then 7 LFSR-driven samples
  task automatic push_bounce(input int ps);
    exp_b.push_back(0);
    exp_p.push_back(ps);
    for (int i = 0; i < 7; i++) begin
      mdl_lfsr = lfsr_step(mdl_lfsr);
      exp_b.push_back(int'(mdl_lfsr[0]));
      exp_p.push_back(ps);
    end
  endtask

  task automatic build(input int n);
    exp_b.delete();
    exp_p.delete();
    for (int p = 0; p < n; p++) begin
      push_bounce(p);
      for (int i = 0; i < 12; i++) begin
        exp_b.push_back(0);
        exp_p.push_back(p);
      end
      push_bounce(p);
      if (p < n - 1) begin
        for (int i = 0; i < 8; i++) begin
          exp_b.push_back(1);
          exp_p.push_back(p + 1);
        end
      end
    end
  endtask

  task automatic run_press(input string tag, input int n);
    int bad_b;
    int bad_p;
    int bad_bz;
    int len;
    bad_b = 0;
    bad_p = 0;
    bad_bz = 0;
    build(n);
    len = exp_b.size();
    chk({tag, "_len"}, len, 28 * n + 8 * (n - 1));
    start = 1'b1;
    press_count = 4'(n);
    tick1();
    start = 1'b0;
    for (int k = 0; k < len; k++) begin
      if (k > 0) tick1();
      if (int'(btn_n) != exp_b[k]) bad_b++;
      if (int'(presses_sent) != exp_p[k]) bad_p++;
      if (!busy || done) bad_bz++;
    end
    chk({tag, "_btn_wave_errs"}, bad_b, 0);
    chk({tag, "_sent_wave_errs"}, bad_p, 0);
    chk({tag, "_busy_errs"}, bad_bz, 0);
    tick1();
    chk({tag, "_done"}, int'(done), 1);
    chk({tag, "_busy_end"}, int'(busy), 0);
    chk({tag, "_btn_end"}, int'(btn_n), 1);
    chk({tag, "_sent_end"}, int'(presses_sent), n);
    tick1();
    chk({tag, "_done_pulse"}, int'(done), 0);
  endtask

  initial begin
    int bad;
    logic [7:0] sv_lfsr;
    rst = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    press_count = 4'd0;
    mdl_lfsr = 8'hA5;
    repeat (3) tick1();
    chk("rst_btn", int'(btn_n), 1);
    chk("rst_busy", int'(busy), 0);
    rst = 1'b0;
    tick1();
    chk("idle_btn", int'(btn_n), 1);
    chk("idle_busy", int'(busy), 0);
    chk("idle_done", int'(done), 0);
    chk("idle_sent", int'(presses_sent), 0);
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      tick1();
      if (!btn_n || busy || done) bad++;
    end
    chk("idle_50", bad, 0);

    run_press("one", 1);
    run_press("three", 3);

    start = 1'b1;
    press_count = 4'd0;
    tick1();
    start = 1'b0;
    chk("zero_done", int'(done), 1);
    chk("zero_busy", int'(busy), 0);
    chk("zero_btn", int'(btn_n), 1);
    tick1();
    chk("zero_done_pulse", int'(done), 0);
    chk("zero_busy2", int'(busy), 0);

    // Abort in HOLD; the model only consumes 7 steps
    sv_lfsr = mdl_lfsr;
    build(2);
    mdl_lfsr = sv_lfsr;
    for (int i = 0; i < 7; i++) mdl_lfsr = lfsr_step(mdl_lfsr);
    start = 1'b1;
    press_count = 4'd2;
    tick1();
    start = 1'b0;
    bad = 0;
    for (int k = 0; k < 15; k++) begin
      if (k > 0) tick1();
      if (k == 3) begin
        start = 1'b1;
        press_count = 4'd5;
      end else begin
        start = 1'b0;
      end
      if (int'(btn_n) != exp_b[k] || !busy) bad++;
    end
    chk("abort_pre_wave", bad, 0);
    abort = 1'b1;
    tick1();
    abort = 1'b0;
    chk("abort_busy", int'(busy), 0);
    chk("abort_btn", int'(btn_n), 1);
    chk("abort_done", int'(done), 0);
    chk("abort_sent", int'(presses_sent), 0);
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      tick1();
      if (done || busy || !btn_n) bad++;
    end
    chk("abort_quiet", bad, 0);

    // Reset mid-HOLD, then reproduce the first post-reset run
    start = 1'b1;
    press_count = 4'd1;
    tick1();
    start = 1'b0;
    repeat (11) tick1();
    chk("hold_low", int'(btn_n), 0);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_btn", int'(btn_n), 1);
    chk("async_rst_busy", int'(busy), 0);
    tick1();
    chk("rst_no_done", int'(done), 0);
    rst = 1'b0;
    tick1();
    mdl_lfsr = 8'hA5;
    run_press("again", 1);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
